// File: rtl/spi_decode_if.sv
// ---------------------------------------------------------------------------
// spi_decode_if
// Groups the SPI pins and the pixel-write result bus of spi_decode.
//   sck      SPI serial clock (mode 0), asynchronous to clk   (master -> slave)
//   sdi      SPI data in, MSB first                            (master -> slave)
//   cs       chip select, active-low                           (master -> slave)
//   sdo      SPI data out, echo of the previous byte           (slave -> master)
//   x, y     write column / row                                (slave -> master)
//   newColor 3-bit color code                                  (slave -> master)
//   brush    brush-active flag                                 (slave -> master)
//   ready    one-cycle strobe, x/y/newColor/brush valid        (slave -> master)
// ---------------------------------------------------------------------------
interface spi_decode_if;
    logic       sck;
    logic       sdi;
    logic       cs;
    logic       sdo;
    logic [7:0] x;
    logic [7:0] y;
    logic [2:0] newColor;
    logic       brush;
    logic       ready;

    modport master (
        output sck, sdi, cs,
        input  sdo, x, y, newColor, brush, ready
    );

    modport slave (
        input  sck, sdi, cs,
        output sdo, x, y, newColor, brush, ready
    );
endinterface

// File: rtl/spi_decode.sv
// ---------------------------------------------------------------------------
// spi_decode
// SPI (mode 0) slave that decodes 3-byte pixel-write packets:
//   byte 0: {3'b101, brush, -, color[2:0]}   byte 1: x   byte 2: y
// Each completed packet updates x/y/newColor/brush and strobes ready for one
// clk cycle. sdo echoes the previous byte, MSB first.
// Ports:
//   clk    system clock, must run at least 4x sck
//   reset  asynchronous, active-high
//   bus    spi_decode_if.slave (sck, sdi, cs in; sdo, x, y, newColor,
//          brush, ready out)
// ---------------------------------------------------------------------------
module spi_decode (
    input  logic         clk,
    input  logic         reset,
    spi_decode_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, CMD, XB, YB, DROP} state_t;

    state_t     r_state, w_state_next;

    logic       r_sck_s1, r_sck_s2, r_sck_d;
    logic       r_sdi_s1, r_sdi_s2;
    logic       r_cs_s1,  r_cs_s2;
    logic [1:0] r_warm;
    logic       r_cs_seen;

    logic [2:0] r_bit_cnt;
    logic [7:0] r_rx;
    logic [7:0] r_byte;
    logic       r_byte_vld;
    logic [7:0] r_tx;
    logic       r_tx_hold;

    logic       r_pend_brush;
    logic [2:0] r_pend_color;
    logic [7:0] r_pend_x;
    logic [7:0] r_x, r_y;
    logic [2:0] r_color;
    logic       r_brush;
    logic       r_ready;

    logic       w_sck_rise, w_sck_fall, w_cs_low;
    logic       w_shift, w_byte_done;
    logic [7:0] w_rx_next;
    logic       w_clr_frame, w_lat_cmd, w_lat_x, w_out_load;

    assign w_cs_low    = ~r_cs_s2;
    assign w_sck_rise  =  r_sck_s2 & ~r_sck_d;
    assign w_sck_fall  = ~r_sck_s2 &  r_sck_d;
    assign w_rx_next   = {r_rx[6:0], r_sdi_s2};
    assign w_shift     = w_sck_rise & w_cs_low & (r_state != IDLE);
    assign w_byte_done = w_shift & (r_bit_cnt == 3'd7);

    // Synchronizers. cs resets high so the bus looks deselected out of reset.
    // r_warm marks when the cs synchronizer holds a real pad sample, so a cs
    // held low through reset is not mistaken for a fresh assertion.
    // NOTE: every clocked register uses <= so all flops sample pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sck_s1  <= 1'b0;
            r_sck_s2  <= 1'b0;
            r_sck_d   <= 1'b0;
            r_sdi_s1  <= 1'b0;
            r_sdi_s2  <= 1'b0;
            r_cs_s1   <= 1'b1;
            r_cs_s2   <= 1'b1;
            r_warm    <= 2'b00;
            r_cs_seen <= 1'b0;
        end else begin
            r_sck_s1  <= bus.sck;
            r_sck_s2  <= r_sck_s1;
            r_sck_d   <= r_sck_s2;
            r_sdi_s1  <= bus.sdi;
            r_sdi_s2  <= r_sdi_s1;
            r_cs_s1   <= bus.cs;
            r_cs_s2   <= r_cs_s1;
            r_warm    <= {r_warm[0], 1'b1};
            if (w_clr_frame)
                r_cs_seen <= 1'b0;
            else if (r_warm[1] && r_cs_s2)
                r_cs_seen <= 1'b1;
        end
    end

    // Receive shifter and bit counter; the 3-bit count wraps to 0 after bit 7.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bit_cnt  <= 3'd0;
            r_rx       <= 8'h00;
            r_byte     <= 8'h00;
            r_byte_vld <= 1'b0;
        end else begin
            r_byte_vld <= 1'b0;
            if (w_clr_frame || !w_cs_low) begin
                r_bit_cnt <= 3'd0;
                r_rx      <= 8'h00;
            end else if (w_shift) begin
                r_rx      <= w_rx_next;
                r_bit_cnt <= r_bit_cnt + 3'd1;
                if (r_bit_cnt == 3'd7) begin
                    r_byte     <= w_rx_next;
                    r_byte_vld <= 1'b1;
                end
            end
        end
    end

    // Transmit shifter. The sck falling edge that closes the last bit of a
    // byte follows the byte-boundary load, so it is skipped (r_tx_hold);
    // otherwise the freshly loaded MSB would be gone before the master
    // samples it on the next rising edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx      <= 8'h00;
            r_tx_hold <= 1'b0;
        end else if (!w_cs_low || w_clr_frame) begin
            r_tx      <= 8'h00;
            r_tx_hold <= 1'b0;
        end else if (w_byte_done) begin
            r_tx      <= w_rx_next;
            r_tx_hold <= 1'b1;
        end else if (w_sck_fall) begin
            if (r_tx_hold)
                r_tx_hold <= 1'b0;
            else
                r_tx <= {r_tx[6:0], 1'b0};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    // Packet FSM. Deselect wins over everything, including a byte that
    // completes in the same cycle, so a partial packet never strobes ready.
    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        w_clr_frame  = 1'b0;
        w_lat_cmd    = 1'b0;
        w_lat_x      = 1'b0;
        w_out_load   = 1'b0;
        if (!w_cs_low) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE: if (r_cs_seen) begin
                    w_state_next = CMD;
                    w_clr_frame  = 1'b1;
                end
                CMD: if (r_byte_vld) begin
                    if (r_byte[7:5] == 3'b101) begin
                        w_lat_cmd    = 1'b1;
                        w_state_next = XB;
                    end else begin
                        w_state_next = DROP;
                    end
                end
                XB: if (r_byte_vld) begin
                    w_lat_x      = 1'b1;
                    w_state_next = YB;
                end
                YB: if (r_byte_vld) begin
                    w_out_load   = 1'b1;
                    w_state_next = CMD;
                end
                DROP:    w_state_next = DROP;
                default: w_state_next = IDLE;
            endcase
        end
    end

    // Pending fields and the output register; outputs move only with ready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend_brush <= 1'b0;
            r_pend_color <= 3'd0;
            r_pend_x     <= 8'h00;
            r_x          <= 8'h00;
            r_y          <= 8'h00;
            r_color      <= 3'd0;
            r_brush      <= 1'b0;
            r_ready      <= 1'b0;
        end else begin
            r_ready <= w_out_load;
            if (!w_cs_low) begin
                r_pend_brush <= 1'b0;
                r_pend_color <= 3'd0;
                r_pend_x     <= 8'h00;
            end else begin
                if (w_lat_cmd) begin
                    r_pend_brush <= r_byte[4];
                    r_pend_color <= r_byte[2:0];
                end
                if (w_lat_x)
                    r_pend_x <= r_byte;
            end
            if (w_out_load) begin
                r_brush <= r_pend_brush;
                r_color <= r_pend_color;
                r_x     <= r_pend_x;
                r_y     <= r_byte;
            end
        end
    end

    assign bus.sdo      = r_tx[7];
    assign bus.x        = r_x;
    assign bus.y        = r_y;
    assign bus.newColor = r_color;
    assign bus.brush    = r_brush;
    assign bus.ready    = r_ready;
endmodule

// File: tb/tb_spi_decode.sv
// ---------------------------------------------------------------------------
// tb_spi_decode
// Directed SPI packets drive spi_decode; expected pixel writes are queued as
// packets are sent and a monitor pops and compares on every ready strobe.
// sdo echo, reset values and output hold behaviour are compared inline.
// ---------------------------------------------------------------------------
module tb_spi_decode;
    localparam int HALF = 8;  // clk cycles per sck half period

    typedef struct packed {
        logic       brush;
        logic [2:0] color;
        logic [7:0] x;
        logic [7:0] y;
    } pkt_t;

    logic clk;
    logic reset;
    int   cyc;
    int   last_rise;
    int   n_checks;
    int   n_fail;
    logic prev_ready;
    logic [7:0] echo_prev;
    pkt_t exp_q[$];
    pkt_t held;

    spi_decode_if bus ();

    spi_decode dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [7:0] b, input int nbits, input logic chk_echo);
        for (int i = 0; i < nbits; i++) begin
            bus.sdi = b[7-i];
            wait_clk(HALF);
            if (chk_echo)
                check("sdo_echo", 32'(bus.sdo), 32'(echo_prev[7-i]));
            bus.sck   = 1'b1;
            last_rise = cyc;
            wait_clk(HALF);
            bus.sck = 1'b0;
        end
        if (nbits == 8)
            echo_prev = b;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic chk_echo);
        send_bits(b, 8, chk_echo);
    endtask

    task automatic cs_low();
        bus.cs    = 1'b0;
        echo_prev = 8'h00;
        wait_clk(HALF);
    endtask

    task automatic cs_high();
        wait_clk(4);
        bus.cs = 1'b1;
        wait_clk(6);
        check("sdo_cs_high", 32'(bus.sdo), 32'd0);
    endtask

    task automatic expect_pkt(input logic brush, input logic [2:0] color,
                              input logic [7:0] x, input logic [7:0] y);
        pkt_t p;
        p.brush = brush;
        p.color = color;
        p.x     = x;
        p.y     = y;
        exp_q.push_back(p);
        held = p;
    endtask

    task automatic check_outputs(input string name, input pkt_t e);
        check({name, "_x"},     32'(bus.x),        32'(e.x));
        check({name, "_y"},     32'(bus.y),        32'(e.y));
        check({name, "_color"}, 32'(bus.newColor), 32'(e.color));
        check({name, "_brush"}, 32'(bus.brush),    32'(e.brush));
        check({name, "_ready"}, 32'(bus.ready),    32'd0);
    endtask

    // Monitor: every ready strobe must match the oldest queued packet.
    initial prev_ready = 1'b0;
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_ready: x=%0h y=%0h color=%0d brush=%0b, no packet expected",
                             bus.x, bus.y, bus.newColor, bus.brush);
                end else begin
                    pkt_t e;
                    e = exp_q.pop_front();
                    check("pkt_brush", 32'(bus.brush),    32'(e.brush));
                    check("pkt_color", 32'(bus.newColor), 32'(e.color));
                    check("pkt_x",     32'(bus.x),        32'(e.x));
                    check("pkt_y",     32'(bus.y),        32'(e.y));
                    check("ready_latency", 32'(cyc - last_rise), 32'd4);
                end
                check("ready_width", 32'(prev_ready), 32'd0);
            end
            prev_ready = bus.ready;
        end else begin
            prev_ready = 1'b0;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        pkt_t zero;
        zero      = '0;
        held      = '0;
        n_checks  = 0;
        n_fail    = 0;
        last_rise = 0;
        echo_prev = 8'h00;
        reset     = 1'b1;
        bus.sck   = 1'b0;
        bus.sdi   = 1'b0;
        bus.cs    = 1'b1;
        wait_clk(3);
        check_outputs("reset", zero);
        check("reset_sdo", 32'(bus.sdo), 32'd0);
        reset = 1'b0;
        wait_clk(6);

        // Single packet with sdo echo 00, A3, 42.
        cs_low();
        expect_pkt(1'b0, 3'd3, 8'h42, 8'h17);
        send_byte(8'hA3, 1'b1);
        send_byte(8'h42, 1'b1);
        send_byte(8'h17, 1'b1);
        cs_high();
        check("pkt1_drained", 32'(exp_q.size()), 32'd0);

        // Two packets inside one cs-low period.
        cs_low();
        expect_pkt(1'b1, 3'd5, 8'h10, 8'h20);
        send_byte(8'hB5, 1'b1);
        send_byte(8'h10, 1'b1);
        send_byte(8'h20, 1'b1);
        expect_pkt(1'b0, 3'd1, 8'hFF, 8'h00);
        send_byte(8'hA1, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h00, 1'b1);
        cs_high();
        check("pkt2_drained", 32'(exp_q.size()), 32'd0);

        // Bad header: everything until cs high is dropped.
        cs_low();
        send_byte(8'h65, 1'b1);
        send_byte(8'h42, 1'b1);
        send_byte(8'h17, 1'b1);
        send_byte(8'hA3, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        cs_high();
        check_outputs("badhdr_hold", held);

        // Abort mid y byte, then a full packet.
        cs_low();
        send_byte(8'hA3, 1'b1);
        send_byte(8'h42, 1'b1);
        send_bits(8'h17, 4, 1'b1);
        cs_high();
        check_outputs("abort_hold", held);
        cs_low();
        expect_pkt(1'b0, 3'd2, 8'h05, 8'h06);
        send_byte(8'hA2, 1'b1);
        send_byte(8'h05, 1'b1);
        send_byte(8'h06, 1'b1);
        cs_high();
        check("abort_drained", 32'(exp_q.size()), 32'd0);

        // Reset during the y byte; cs stays low so the next packet is ignored
        // until cs is seen high and low again.
        cs_low();
        send_byte(8'hA3, 1'b1);
        send_byte(8'h42, 1'b1);
        send_bits(8'h17, 4, 1'b1);
        reset = 1'b1;
        wait_clk(3);
        check_outputs("midreset", zero);
        check("midreset_sdo", 32'(bus.sdo), 32'd0);
        reset = 1'b0;
        wait_clk(HALF);
        send_byte(8'hA3, 1'b0);
        send_byte(8'h42, 1'b0);
        send_byte(8'h17, 1'b0);
        wait_clk(HALF);
        check_outputs("postreset_ignored", zero);
        cs_high();
        cs_low();
        expect_pkt(1'b0, 3'd6, 8'h33, 8'h44);
        send_byte(8'hA6, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        cs_high();
        check_outputs("postreset_final", held);

        wait_clk(20);
        check("final_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_decode.md
SPI_DECODE -- requirements
Module: spi_decode

Interface
REQ-001 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port sck  input  1  SPI serial clock, mode 0, asynchronous to clk.
REQ-004 SHALL have port sdi  input  1  SPI data in, MSB first.
REQ-005 SHALL have port cs  input  1  chip select, active-low; framing of packets.
REQ-006 SHALL have port sdo  output  1  SPI data out, echo of the previous byte.
REQ-007 SHALL have port x  output  8  write column, to the pixel store.
REQ-008 SHALL have port y  output  8  write row, to the pixel store.
REQ-009 SHALL have port newColor  output  3  color code to write.
REQ-010 SHALL have port brush  output  1  brush-active flag.
REQ-011 SHALL have port ready  output  1  one-cycle strobe; x/y/newColor/brush valid.

Function
REQ-012 SHALL pass sck, sdi and cs each through a 2-flop synchronizer before use; clk frequency SHALL be at least 4x sck.
REQ-013 SHALL detect sck rising and falling edges from the synchronized sck and its 1-cycle-delayed copy.
REQ-014 SHALL shift synchronized sdi into an 8-bit rx register (MSB first) on each detected sck rising edge while cs is low.
REQ-015 SHALL count bits 0..7; on the 8th rising edge it SHALL deliver the completed byte to the packet FSM and reset the bit count to 0.
REQ-016 SHALL implement FSM states IDLE, CMD, XB, YB, DROP.
REQ-017 IDLE -> CMD when synchronized cs goes low; bit count and rx register SHALL clear on that transition.
REQ-018 In CMD, on a byte whose [7:5] == 3'b101, it SHALL latch [4] as pending brush and [2:0] as pending color, then go to XB; byte[3] is ignored.
REQ-019 In CMD, on a byte whose [7:5] != 3'b101, it SHALL go to DROP and ignore bytes until cs goes high.
REQ-020 In XB, on byte completion, it SHALL latch the byte as pending x and go to YB.
REQ-021 In YB, on byte completion, it SHALL register pending brush/color/x and the new byte into brush/newColor/x/y, pulse ready high for exactly one clk cycle on the following clock edge, and return to CMD.
REQ-022 Back-to-back packets within one cs-low period SHALL each produce one ready pulse.
REQ-023 When cs goes high in any state, the FSM SHALL go to IDLE, discard pending fields and any partial byte, and SHALL NOT pulse ready.
REQ-024 x, y, newColor and brush SHALL hold their values between ready pulses and change only with a ready pulse.
REQ-025 sdo SHALL be bit 7 of an 8-bit tx register.
REQ-026 The tx register SHALL load 8'h00 on cs assertion.
REQ-027 The tx register SHALL load the just-completed rx byte at each byte boundary.
REQ-028 Otherwise, the tx register SHALL shift left, filling with 0, on each detected sck falling edge while cs is low.
REQ-029 sdo SHALL be 0 whenever cs is high.
REQ-030 Latency from the sck rising edge of the last y bit to ready high SHALL be 4 clk cycles: 2 synchronizer cycles, 1 edge-detect cycle, 1 output-register cycle.

Reset
REQ-031 While reset is high, outputs SHALL be x=0, y=0, newColor=0, brush=0, ready=0, sdo=0.
REQ-032 While reset is high, the FSM SHALL be IDLE, bit count 0, and rx/tx registers and synchronizers 0 (cs synchronizer 1).
REQ-033 Reset asserted mid-packet SHALL abort the packet without a ready pulse.
REQ-034 After reset deasserts, a packet SHALL be accepted only after cs is observed high and then low.

Verification
REQ-035 Single packet: cs low; send bytes A3, 42, 17; cs high -> one ready pulse with brush=0, newColor=3, x=8'h42, y=8'h17.
REQ-036 Two packets in one cs-low period: B5,10,20 then A1,FF,00 -> two ready pulses; first brush=1, newColor=5, x=10, y=20; then brush=0, newColor=1, x=FF, y=00.
REQ-037 Bad header: cs low; send 65, 42, 17, A3, 01, 02 -> no ready pulse; outputs keep prior values.
REQ-038 Abort: send A3, 42, then 4 bits of the y byte, then cs high; next full packet A2,05,06 -> exactly one ready pulse, with x=05, y=06, newColor=2.
REQ-039 Echo: send A3, 42, 17 -> sdo shows 00, A3, 42 MSB-first across the three bytes.
REQ-040 Reset during the y byte, then a full packet after cs toggles -> outputs 0 until the new packet, then a single correct ready pulse.
